// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter with synchronous clear, enable and terminal-count decode.
module piso_bit_cnt #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned MAX   = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear wins so a reload on the final bit restarts cleanly at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer with valid/ready load and stallable shift-out.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             lsb_first,
  output logic             load_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             order_q, order_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic             cnt_tc;
  logic             cnt_en;
  logic             handshake;
  logic             data_bit;

  assign handshake = load_valid && load_ready;
  assign cnt_en    = (state_q == StShift) && ser_en;

  piso_bit_cnt #(
    .CNT_W (CNT_W),
    .MAX   (WIDTH - 1)
  ) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (handshake),
    .en      (cnt_en),
    .cnt     (bit_cnt),
    .tc      (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      order_q <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      order_q <= order_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = handshake ? load_data : data_q;
    order_d = handshake ? lsb_first : order_q;
    unique case (state_q)
      StIdle: begin
        if (load_valid) state_d = StShift;
      end
      StShift: begin
        if (ser_en && cnt_tc) begin
`ifdef PISO_PARITY_EN
          state_d = StParity;
`else
          state_d = load_valid ? StShift : StIdle;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        if (ser_en) state_d = load_valid ? StShift : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Bit order is taken from the captured flag, never the live input.
  assign bit_idx = (order_q == LSB_FIRST) ? bit_cnt : CNT_W'(WIDTH - 1) - bit_cnt;

  always_comb begin
    data_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bit_idx == CNT_W'(i)) data_bit = data_q[i];
    end
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StShift: begin
        ser_out   = data_bit;
        ser_valid = 1'b1;
        busy      = 1'b1;
`ifndef PISO_PARITY_EN
        ser_last  = cnt_tc;
`endif
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        ser_out   = ^data_q;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        busy      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Held low during reset so nothing upstream sees a handshake it cannot get.
  assign load_ready = reset_n && ((state_q == StIdle) || (ser_last && ser_en));

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer; successor to the fixed 4-bit PISO. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle, MSB-first or LSB-first per word. Back-to-back words stream with no idle gap, and a stall input freezes the output. It sits between a parallel producer and any single-wire serial consumer in the design.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- load_valid  input  1  producer has a word on load_data
- load_data  input  WIDTH  parallel word
- lsb_first  input  1  bit order for this word; sampled with the load (0 = MSB-first)
- load_ready  output  1  block will accept a word this cycle
- ser_en  input  1  advance one bit this cycle; 0 = stall
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out carries a frame bit
- ser_last  output  1  ser_out is the final bit of the frame
- busy  output  1  a frame is in progress

## Operation
- States: IDLE, SHIFT (plus PARITY when PISO_PARITY_EN is defined).
- IDLE: load_ready=1, ser_valid=0, ser_out=0. Handshake on load_valid && load_ready -> capture load_data and lsb_first, bit_cnt=0, go to SHIFT.
- SHIFT: ser_out = data bit selected by order (bit WIDTH-1-bit_cnt for MSB-first, bit bit_cnt for LSB-first); ser_valid=1, busy=1. When ser_en=1, bit_cnt++; when ser_en=0, everything holds.
- ser_last=1 on the final frame bit (bit_cnt==WIDTH-1 without parity; PARITY state with parity).
- load_ready = (state==IDLE) || (ser_last && ser_en); combinational.
- Final bit consumed (ser_last && ser_en):
  - If a handshake occurs in the same cycle, reload and restart SHIFT. No gap.
  - Otherwise, go to IDLE.
- load_valid while load_ready=0 is ignored. The producer must hold the word until the handshake.
- Changing lsb_first mid-frame has no effect on the current frame.

## Timing
- Reset (async assert, sync to next edge on deassert): state=IDLE, shift reg=0, bit_cnt=0, ser_out=0, ser_valid=0, ser_last=0, busy=0; load_ready=1 once out of reset.
- Latency: handshake at edge N -> first bit valid after edge N, held until the first edge with ser_en=1.
- Frame length: WIDTH enabled cycles (WIDTH+1 with parity). Throughput is one bit per enabled cycle, continuous across words.
- Reset asserted mid-frame: outputs drop to their reset values immediately; the partial frame is discarded, with no resume.
- Stall on the last bit: load_ready stays 0 until ser_en=1.

## Configuration
- PISO_PARITY_EN defined: after the WIDTH data bits, one PARITY-state bit = even parity (XOR of the captured word). ser_last is on this bit, and the frame is WIDTH+1 bits.
- Not defined: no PARITY state; ser_last is on data bit WIDTH-1; frame is WIDTH bits.

## Structure
- Package piso_pkg holds:
  - the state enum (IDLE/SHIFT/PARITY)
  - the bit-order constants MSB_FIRST=0 and LSB_FIRST=1
- One sub-module, piso_bit_cnt: parametrised counter with clear, enable and terminal-count output. It drives bit_cnt and the ser_last decode.
- Shift register, order mux and parity XOR live in the top.

## Test plan
- Reset with load_valid=1 -> all outputs 0, no capture; after deassert load_ready=1, ser_valid=0.
- WIDTH=8, load 0xB1, lsb_first=0, ser_en=1 -> ser_out 1,0,1,1,0,0,0,1 on 8 consecutive cycles; ser_last only on the 8th; then IDLE.
- Load 0xB1, lsb_first=1 -> 1,0,0,0,1,1,0,1.
- 0xA5 then 0x3C with load_valid held, MSB-first -> 16 consecutive ser_valid cycles 10100101 00111100, with load_ready pulsing only on the 8th bit.
- ser_en low for 3 cycles after bit 2 of 0xA5 -> ser_out holds bit 2, load_ready=0, busy=1; the stream resumes unchanged.
- Reset pulse after bit 3 -> ser_valid falls the same cycle; a new load of 0xFF emits 8 ones. With PISO_PARITY_EN: 0xB1 -> 9th bit 0 with ser_last, and 0x07 -> 9th bit 1.
